// File: rtl/filter_pattern_gen.sv
// ---------------------------------------------------------------------------
// filter_pattern_gen
//   Self-test pattern source for the sampler/noise-filter input pair. It drives
//   programmable multi-channel pulse trains on dataOutput/dataOutput180. It also
//   injects half-cycle glitches on dataOutput180 only. A loopback bench can then
//   show that real pulses pass the filter and that glitches are rejected.
//
//   Optional feature: define PATGEN_WALK_EN to enable walking-pattern mode.
//   In that mode register 5 bit 0 selects a pattern that rotates by one bit
//   every period.
//
// Ports
//   clock          in   single clock, all logic on posedge
//   resetN         in   asynchronous active-low reset
//   wrEnable       in   register write strobe (ignored while busy)
//   wrAddr[2:0]    in   register select: 0 chanMask, 1 glitchMask, 2 highLen,
//                       3 lowLen, 4 pulseCount, 5 mode (walk builds only)
//   wrData[31:0]   in   register write data
//   start          in   begin a pulse train (sampled in IDLE only)
//   stop           in   abort the pulse train (wins over start)
//   busy           out  high while a train is running
//   done           out  one-cycle pulse when a counted train completes
//   dataOutput     out  rising-edge-phase sample data
//   dataOutput180  out  falling-edge-phase sample data
// ---------------------------------------------------------------------------
module filter_pattern_gen #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             wrEnable,
    input  logic [2:0]       wrAddr,
    input  logic [31:0]      wrData,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOutput,
    output logic [WIDTH-1:0] dataOutput180
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] phase_q, phase_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;

    logic [WIDTH-1:0]     chanMask_q, glitchMask_q;
    logic [CNT_WIDTH-1:0] highLen_q, lowLen_q, pulseCount_q;

    logic [WIDTH-1:0]     dout_q, dout_d;
    logic [WIDTH-1:0]     dout180_q, dout180_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     staticPat, glitchSet, activePat;
    logic [CNT_WIDTH-1:0] highLast, lowLast;
    logic                 startOk, lowToHigh;

    assign staticPat = chanMask_q & ~glitchMask_q;
    assign glitchSet = chanMask_q & glitchMask_q;

    // A programmed length of 0 behaves as 1, so the terminal phase index is 0.
    assign highLast = (highLen_q == '0) ? '0 : highLen_q - CNT_WIDTH'(1);
    assign lowLast  = (lowLen_q  == '0) ? '0 : lowLen_q  - CNT_WIDTH'(1);

    assign startOk   = (state_q == S_IDLE) && start && !stop;
    assign lowToHigh = (state_q == S_LOW) && (state_d == S_HIGH);

    // Configuration registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            chanMask_q   <= '0;
            glitchMask_q <= '0;
            highLen_q    <= '0;
            lowLen_q     <= '0;
            pulseCount_q <= '0;
        end else if (wrEnable && (state_q == S_IDLE)) begin
            case (wrAddr)
                3'd0:    chanMask_q   <= wrData[WIDTH-1:0];
                3'd1:    glitchMask_q <= wrData[WIDTH-1:0];
                3'd2:    highLen_q    <= wrData[CNT_WIDTH-1:0];
                3'd3:    lowLen_q     <= wrData[CNT_WIDTH-1:0];
                3'd4:    pulseCount_q <= wrData[CNT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

`ifdef PATGEN_WALK_EN
    logic             mode_q;
    logic [WIDTH-1:0] walk_q, walk_d;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mode_q <= 1'b0;
            walk_q <= '0;
        end else begin
            if (wrEnable && (state_q == S_IDLE) && (wrAddr == 3'd5)) begin
                mode_q <= wrData[0];
            end
            walk_q <= walk_d;
        end
    end

    // The walking register loads at start and rotates left on each LOW->HIGH turn.
    // The output uses the next value so the first HIGH phase shows the loaded pattern.
    always_comb begin
        walk_d = walk_q;
        if (startOk) begin
            walk_d = staticPat;
        end else if (lowToHigh) begin
            walk_d = {walk_q[WIDTH-2:0], walk_q[WIDTH-1]};
        end
    end

    assign activePat = mode_q ? walk_d : staticPat;
`else
    assign activePat = staticPat;
`endif

    // FSM state and counters
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            period_q <= period_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        period_d = period_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (startOk) begin
                    state_d  = S_HIGH;
                    phase_d  = '0;
                    period_d = '0;
                end
            end
            S_HIGH: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (phase_q == highLast) begin
                    state_d = S_LOW;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + CNT_WIDTH'(1);
                end
            end
            S_LOW: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (phase_q == lowLast) begin
                    // The period counter wraps freely when pulseCount is 0.
                    period_d = period_q + CNT_WIDTH'(1);
                    phase_d  = '0;
                    if ((pulseCount_q != '0) && (period_d == pulseCount_q)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_HIGH;
                    end
                end else begin
                    phase_d = phase_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with state_q.
    // The glitch appears on dataOutput180 only in the first LOW cycle.
    always_comb begin
        dout_d    = '0;
        dout180_d = '0;
        busy_d    = (state_d != S_IDLE);
        if (state_d == S_HIGH) begin
            dout_d    = activePat;
            dout180_d = activePat;
        end else if ((state_d == S_LOW) && (state_q == S_HIGH)) begin
            dout180_d = glitchSet;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            dout_q    <= '0;
            dout180_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            dout180_q <= dout180_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign dataOutput    = dout_q;
    assign dataOutput180 = dout180_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_filter_pattern_gen.sv
module tb_filter_pattern_gen;

    logic        clock = 1'b0;
    logic        resetN;
    logic        wrEnable;
    logic [2:0]  wrAddr;
    logic [31:0] wrData;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic [31:0] dataOutput;
    logic [31:0] dataOutput180;

    filter_pattern_gen #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clock         (clock),
        .resetN        (resetN),
        .wrEnable      (wrEnable),
        .wrAddr        (wrAddr),
        .wrData        (wrData),
        .start         (start),
        .stop          (stop),
        .busy          (busy),
        .done          (done),
        .dataOutput    (dataOutput),
        .dataOutput180 (dataOutput180)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned cyc;
        logic [31:0] d;
        logic [31:0] d180;
        logic        b;
        logic        dn;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          passed = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compares every expected entry whose cycle has arrived.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (dataOutput === e.d && dataOutput180 === e.d180 &&
                busy === e.b && done === e.dn) begin
                passed++;
            end else begin
                $display("FAIL %s cyc=%0d got d=%h d180=%h busy=%b done=%b expected d=%h d180=%h busy=%b done=%b",
                         e.nm, cyc, dataOutput, dataOutput180, busy, done,
                         e.d, e.d180, e.b, e.dn);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Push n identical expectations starting at cycle offset off.
    task automatic exp_phase(input int unsigned off, input int unsigned n,
                             input logic [31:0] d, input logic [31:0] d180,
                             input logic b, input logic dn, input string nm);
        for (int unsigned k = 0; k < n; k++) begin
            exp_t e;
            e.cyc  = cyc + off + k;
            e.d    = d;
            e.d180 = d180;
            e.b    = b;
            e.dn   = dn;
            e.nm   = nm;
            sb.push_back(e);
        end
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] v);
        wrEnable = 1'b1;
        wrAddr   = a;
        wrData   = v;
        tick();
        wrEnable = 1'b0;
    endtask

    task automatic program_regs(input logic [31:0] chan, input logic [31:0] glit,
                                input logic [31:0] hl, input logic [31:0] ll,
                                input logic [31:0] pc);
        write_reg(3'd0, chan);
        write_reg(3'd1, glit);
        write_reg(3'd2, hl);
        write_reg(3'd3, ll);
        write_reg(3'd4, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        resetN   = 1'b0;
        wrEnable = 1'b0;
        wrAddr   = '0;
        wrData   = '0;
        start    = 1'b0;
        stop     = 1'b0;
        tick();
        exp_phase(0, 1, 32'h0, 32'h0, 1'b0, 1'b0, "reset_held");
        tick();
        resetN = 1'b1;
        exp_phase(1, 1, 32'h0, 32'h0, 1'b0, 1'b0, "reset_released");
        tick();

        // Basic train: 0xFF, high 3, low 2, two periods.
        program_regs(32'hFF, 32'h0, 32'd3, 32'd2, 32'd2);
        start = 1'b1;
        exp_phase(1,  3, 32'hFF, 32'hFF, 1'b1, 1'b0, "basic_high1");
        exp_phase(4,  2, 32'h00, 32'h00, 1'b1, 1'b0, "basic_low1");
        exp_phase(6,  3, 32'hFF, 32'hFF, 1'b1, 1'b0, "basic_high2");
        exp_phase(9,  2, 32'h00, 32'h00, 1'b1, 1'b0, "basic_low2");
        exp_phase(11, 1, 32'h00, 32'h00, 1'b0, 1'b1, "basic_done");
        exp_phase(12, 1, 32'h00, 32'h00, 1'b0, 1'b0, "basic_idle");
        tick();
        start = 1'b0;
        repeat (13) tick();

        // Glitch mask: bits 7:4 pulse, bits 3:0 only on 180 in first LOW cycle.
        write_reg(3'd1, 32'h0F);
        start = 1'b1;
        exp_phase(1,  3, 32'hF0, 32'hF0, 1'b1, 1'b0, "glitch_high1");
        exp_phase(4,  1, 32'h00, 32'h0F, 1'b1, 1'b0, "glitch_low1a");
        exp_phase(5,  1, 32'h00, 32'h00, 1'b1, 1'b0, "glitch_low1b");
        exp_phase(6,  3, 32'hF0, 32'hF0, 1'b1, 1'b0, "glitch_high2");
        exp_phase(9,  1, 32'h00, 32'h0F, 1'b1, 1'b0, "glitch_low2a");
        exp_phase(10, 1, 32'h00, 32'h00, 1'b1, 1'b0, "glitch_low2b");
        exp_phase(11, 1, 32'h00, 32'h00, 1'b0, 1'b1, "glitch_done");
        exp_phase(12, 1, 32'h00, 32'h00, 1'b0, 1'b0, "glitch_idle");
        tick();
        start = 1'b0;
        repeat (13) tick();

        // Reset asserted in the middle of a HIGH phase clears outputs at once.
        write_reg(3'd1, 32'h0);
        write_reg(3'd4, 32'h0);
        start = 1'b1;
        exp_phase(1, 1, 32'hFF, 32'hFF, 1'b1, 1'b0, "rst_pre_high");
        tick();
        start = 1'b0;
        tick();
        resetN = 1'b0;
        exp_phase(0, 1, 32'h0, 32'h0, 1'b0, 1'b0, "rst_async");
        exp_phase(1, 2, 32'h0, 32'h0, 1'b0, 1'b0, "rst_hold");
        repeat (2) tick();
        resetN = 1'b1;
        exp_phase(1, 2, 32'h0, 32'h0, 1'b0, 1'b0, "rst_after");
        repeat (3) tick();

        // Zero lengths, continuous mode: toggles every cycle until stop.
        program_regs(32'h1, 32'h0, 32'd0, 32'd0, 32'd0);
        start = 1'b1;
        for (int unsigned k = 1; k <= 8; k++) begin
            if (k % 2 == 1)
                exp_phase(k, 1, 32'h1, 32'h1, 1'b1, 1'b0, "toggle_high");
            else
                exp_phase(k, 1, 32'h0, 32'h0, 1'b1, 1'b0, "toggle_low");
        end
        tick();
        start = 1'b0;
        repeat (7) tick();
        stop = 1'b1;
        exp_phase(1, 3, 32'h0, 32'h0, 1'b0, 1'b0, "stop_idle");
        tick();
        stop = 1'b0;
        repeat (4) tick();

        // start and stop together in IDLE: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        exp_phase(1, 2, 32'h0, 32'h0, 1'b0, 1'b0, "start_stop_idle");
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) tick();

        // Write while busy is ignored; single-period train is the boundary case.
        program_regs(32'hFF, 32'h0, 32'd1, 32'd1, 32'd1);
        start = 1'b1;
        exp_phase(1, 1, 32'hFF, 32'hFF, 1'b1, 1'b0, "busywr_high");
        exp_phase(2, 1, 32'h00, 32'h00, 1'b1, 1'b0, "busywr_low");
        exp_phase(3, 1, 32'h00, 32'h00, 1'b0, 1'b1, "busywr_done");
        tick();
        start = 1'b0;
        write_reg(3'd0, 32'hF00);
        repeat (3) tick();
        start = 1'b1;
        exp_phase(1, 1, 32'hFF, 32'hFF, 1'b1, 1'b0, "readback_high");
        exp_phase(2, 1, 32'h00, 32'h00, 1'b1, 1'b0, "readback_low");
        exp_phase(3, 1, 32'h00, 32'h00, 1'b0, 1'b1, "readback_done");
        tick();
        start = 1'b0;
        repeat (4) tick();

`ifdef PATGEN_WALK_EN
        // Walking mode: one-hot pattern rotates each period.
        program_regs(32'h1, 32'h0, 32'd1, 32'd1, 32'd4);
        write_reg(3'd5, 32'h1);
        start = 1'b1;
        exp_phase(1, 1, 32'h1, 32'h1, 1'b1, 1'b0, "walk_h0");
        exp_phase(2, 1, 32'h0, 32'h0, 1'b1, 1'b0, "walk_l0");
        exp_phase(3, 1, 32'h2, 32'h2, 1'b1, 1'b0, "walk_h1");
        exp_phase(4, 1, 32'h0, 32'h0, 1'b1, 1'b0, "walk_l1");
        exp_phase(5, 1, 32'h4, 32'h4, 1'b1, 1'b0, "walk_h2");
        exp_phase(6, 1, 32'h0, 32'h0, 1'b1, 1'b0, "walk_l2");
        exp_phase(7, 1, 32'h8, 32'h8, 1'b1, 1'b0, "walk_h3");
        exp_phase(8, 1, 32'h0, 32'h0, 1'b1, 1'b0, "walk_l3");
        exp_phase(9, 1, 32'h0, 32'h0, 1'b0, 1'b1, "walk_done");
        tick();
        start = 1'b0;
        repeat (10) tick();
`endif

        repeat (3) tick();
        checks++;
        if (sb.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
